// File: rtl/fc_acc_bank.sv
// Bias-preloaded bank of saturating signed accumulators with a serial valid/ready drain and running argmax.
// Define RELU_EN to clamp drained values at zero before output and argmax comparison.
module fc_acc_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 24,
    parameter int NUM_CH     = 10,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           bias_sel,
    input  logic                           acc_en,
    input  logic                           done,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   data_in,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   bias_in,
    output logic                           busy,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [IDX_WIDTH-1:0]           out_idx,
    output logic                           class_valid,
    output logic [IDX_WIDTH-1:0]           class_idx
);

    // Stream handshake: a sample transfers on a rising edge where out_valid && out_ready;
    // out_data/out_idx are held while out_valid && !out_ready.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic signed [ACC_WIDTH-1:0]  ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0]  ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] DATA_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] DATA_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [IDX_WIDTH-1:0]         LAST_IDX = IDX_WIDTH'(NUM_CH - 1);

    state_t state_q, state_d;

    logic signed [ACC_WIDTH-1:0]  acc_q [NUM_CH];
    logic signed [ACC_WIDTH-1:0]  acc_d [NUM_CH];
    logic signed [DATA_WIDTH-1:0] max_q;
    logic [IDX_WIDTH-1:0]         best_q;

    logic                         handshake;
    logic                         last_hs;
    logic                         take_max;
    logic                         enter_drain;
    logic [IDX_WIDTH-1:0]         nxt_idx;

    function automatic logic signed [ACC_WIDTH-1:0] sext_in(input logic signed [DATA_WIDTH-1:0] v);
        return ACC_WIDTH'(v);
    endfunction

    // Add one extra bit of headroom; a sign mismatch between the top two bits means overflow.
    function automatic logic signed [ACC_WIDTH-1:0] sat_add(
        input logic signed [ACC_WIDTH-1:0]  a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        logic signed [ACC_WIDTH:0] s;
        s = (ACC_WIDTH+1)'(a) + (ACC_WIDTH+1)'(b);
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
            return s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        return s[ACC_WIDTH-1:0];
    endfunction

    // The value fits DATA_WIDTH only when all bits above the data sign bit match it.
    function automatic logic signed [DATA_WIDTH-1:0] sat_out(input logic signed [ACC_WIDTH-1:0] a);
        logic signed [DATA_WIDTH-1:0] r;
        if ((&a[ACC_WIDTH-1:DATA_WIDTH-1]) || !(|a[ACC_WIDTH-1:DATA_WIDTH-1]))
            r = a[DATA_WIDTH-1:0];
        else
            r = a[ACC_WIDTH-1] ? DATA_MIN : DATA_MAX;
`ifdef RELU_EN
        if (r[DATA_WIDTH-1])
            r = '0;
`endif
        return r;
    endfunction

    assign handshake   = (state_q == DRAIN) && out_valid && out_ready;
    assign last_hs     = handshake && (out_idx == LAST_IDX);
    assign take_max    = (out_idx == '0) || ($signed(out_data) > max_q);
    assign enter_drain = (state_q == ACC) && (state_d == DRAIN);
    assign nxt_idx     = out_idx + IDX_WIDTH'(1);
    assign busy        = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bias_sel)
                    state_d = ACC;
            end
            ACC: begin
                if (!bias_sel && done)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (last_hs)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            acc_d[k] = acc_q[k];
            if (state_q != DRAIN) begin
                if (bias_sel)
                    acc_d[k] = sext_in(bias_in[k*DATA_WIDTH +: DATA_WIDTH]);
                else if ((state_q == ACC) && acc_en)
                    acc_d[k] = sat_add(acc_q[k], data_in[k*DATA_WIDTH +: DATA_WIDTH]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            for (int k = 0; k < NUM_CH; k++)
                acc_q[k] <= '0;
        end else begin
            state_q <= state_d;
            for (int k = 0; k < NUM_CH; k++)
                acc_q[k] <= acc_d[k];
        end
    end

    // Channel 0 is loaded from acc_d so a final addition sampled with done is included.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_idx     <= '0;
            class_valid <= 1'b0;
            class_idx   <= '0;
            max_q       <= '0;
            best_q      <= '0;
        end else begin
            class_valid <= 1'b0;
            if (enter_drain) begin
                out_valid <= 1'b1;
                out_idx   <= '0;
                out_data  <= sat_out(acc_d[0]);
            end else if (handshake) begin
                if (take_max) begin
                    max_q  <= $signed(out_data);
                    best_q <= out_idx;
                end
                if (last_hs) begin
                    out_valid   <= 1'b0;
                    class_valid <= 1'b1;
                    class_idx   <= take_max ? out_idx : best_q;
                end else begin
                    out_idx  <= nxt_idx;
                    out_data <= sat_out(acc_q[nxt_idx]);
                end
            end
        end
    end

endmodule

// File: tb/tb_fc_acc_bank.sv
// Scoreboard bench for fc_acc_bank: a channel-level reference model queues expected drain samples
// and class indices; a negedge monitor pops and compares them as the DUT presents them.
module tb_fc_acc_bank;

  localparam int DW = 16;
  localparam int AW = 24;
  localparam int NC = 10;
  localparam int IW = 4;
  localparam int SW = NC * DW;

  localparam longint AMAX = (longint'(1) << (AW - 1)) - 1;
  localparam longint AMIN = -(longint'(1) << (AW - 1));
  localparam longint DMAX = (longint'(1) << (DW - 1)) - 1;
  localparam longint DMIN = -(longint'(1) << (DW - 1));

  logic clk;
  logic reset;
  logic bias_sel;
  logic acc_en;
  logic done;
  logic [SW-1:0] data_in;
  logic [SW-1:0] bias_in;
  logic busy;
  logic out_valid;
  logic out_ready;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic class_valid;
  logic [IW-1:0] class_idx;

  fc_acc_bank #(
    .DATA_WIDTH(DW),
    .ACC_WIDTH(AW),
    .NUM_CH(NC),
    .IDX_WIDTH(IW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bias_sel(bias_sel),
    .acc_en(acc_en),
    .done(done),
    .data_in(data_in),
    .bias_in(bias_in),
    .busy(busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_idx(out_idx),
    .class_valid(class_valid),
    .class_idx(class_idx)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int n_cmp = 0;
  int n_fail = 0;
  logic [IW+DW-1:0] exp_q[$];
  logic [IW-1:0] cls_q[$];
  longint m_acc[NC];
  bit m_active = 0;
  bit m_draining = 0;
  int ready_mode = 0;
  int rdy_cnt = 0;
  int hs_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint sx(input logic [SW-1:0] v, input int k);
    logic [DW-1:0] f;
    f = v[k*DW +: DW];
    return longint'($signed(f));
  endfunction

  function automatic logic [SW-1:0] rand_vec(input int lo, input int hi);
    logic [SW-1:0] v;
    for (int k = 0; k < NC; k++)
      v[k*DW +: DW] = DW'(lo + int'($urandom_range(0, hi - lo)));
    return v;
  endfunction

  // reference: per-channel saturated totals, first-max-wins argmax
  task automatic push_drain();
    longint v;
    longint best_v;
    int best;
    best_v = 0;
    best = 0;
    for (int k = 0; k < NC; k++) begin
      v = clamp(m_acc[k], DMIN, DMAX);
`ifdef RELU_EN
      if (v < 0) v = 0;
`endif
      exp_q.push_back({IW'(k), DW'(v)});
      if (k == 0 || v > best_v) begin
        best_v = v;
        best = k;
      end
    end
    cls_q.push_back(IW'(best));
  endtask

  // driver: one clock of control inputs, then apply the same operation to the model
  task automatic cycle(input bit bs, input bit ae, input bit dn,
                       input logic [SW-1:0] d, input logic [SW-1:0] b);
    bit go_drain;
    go_drain = 0;
    bias_sel = bs;
    acc_en = ae;
    done = dn;
    data_in = d;
    bias_in = b;
    @(posedge clk);
    #1;
    if (!m_draining) begin
      if (bs) begin
        for (int k = 0; k < NC; k++) m_acc[k] = sx(b, k);
        m_active = 1;
      end else if (m_active) begin
        if (ae)
          for (int k = 0; k < NC; k++) m_acc[k] = clamp(m_acc[k] + sx(d, k), AMIN, AMAX);
        if (dn) begin
          m_draining = 1;
          go_drain = 1;
          push_drain();
        end
      end
    end
    bias_sel = 0;
    acc_en = 0;
    done = 0;
    if (go_drain) check("first_valid_latency", 64'(out_valid), 64'(1));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cls_q.size() != 0) && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (n >= 400) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d samples and %0d classes still pending", exp_q.size(), cls_q.size());
      exp_q.delete();
      cls_q.delete();
    end
    @(posedge clk);
    #1;
    check("busy_after_drain", 64'(busy), 64'(0));
    m_draining = 0;
    m_active = 0;
  endtask

  // downstream ready generator
  always @(posedge clk) begin
    #1;
    rdy_cnt++;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = (rdy_cnt % 3 == 0);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // monitor
  logic stall_prev = 0;
  logic last_prev = 0;
  logic [DW-1:0] stall_data;
  logic [IW-1:0] stall_idx;
  always @(negedge clk) begin
    logic [IW+DW-1:0] e;
    if (reset) begin
      stall_prev = 0;
      last_prev = 0;
    end else begin
      if (last_prev) check("class_valid_timing", 64'(class_valid), 64'(1));
      if (stall_prev) begin
        check("hold_valid", 64'(out_valid), 64'(1));
        check("hold_data", 64'(out_data), 64'(stall_data));
        check("hold_idx", 64'(out_idx), 64'(stall_idx));
      end
      if (class_valid) begin
        if (cls_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_class_valid: class_idx=%0d with none expected", class_idx);
        end else begin
          check("class_idx", 64'(class_idx), 64'(cls_q.pop_front()));
        end
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_sample: idx=%0d data=0x%0h with none expected", out_idx, out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_idx", 64'(out_idx), 64'(e[IW+DW-1:DW]));
          check("out_data", 64'(out_data), 64'(e[DW-1:0]));
        end
      end
      last_prev = out_valid && out_ready && (out_idx == IW'(NC - 1));
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      stall_idx = out_idx;
    end
  end

  // stimulus
  initial begin
    logic [SW-1:0] b;
    logic [SW-1:0] d;
    int h0;
    int n;

    reset = 1;
    bias_sel = 0;
    acc_en = 0;
    done = 0;
    data_in = '0;
    bias_in = '0;
    out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_idx", 64'(out_idx), 64'(0));
    check("rst_class_valid", 64'(class_valid), 64'(0));
    check("rst_class_idx", 64'(class_idx), 64'(0));
    reset = 0;
    @(posedge clk);
    #1;

    // acc_en and done alone are ignored in IDLE
    cycle(0, 1, 0, rand_vec(-100, 100), '0);
    cycle(0, 0, 1, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("idle_ignore_busy", 64'(busy), 64'(0));
    check("idle_ignore_valid", 64'(out_valid), 64'(0));

    // bias k, three additions of 100
    for (int k = 0; k < NC; k++) b[k*DW +: DW] = DW'(k);
    for (int k = 0; k < NC; k++) d[k*DW +: DW] = DW'(100);
    cycle(1, 0, 0, '0, b);
    check("busy_in_acc", 64'(busy), 64'(1));
    repeat (3) cycle(0, 1, 0, d, '0);
    cycle(0, 0, 1, '0, '0);
    wait_drain();

    // output saturation on channel 3 (positive) and channel 4 (-70000)
    b = rand_vec(-1000, 1000);
    d = rand_vec(-1000, 1000);
    b[3*DW +: DW] = 16'h7000;
    d[3*DW +: DW] = 16'h7000;
    b[4*DW +: DW] = DW'(-30000);
    d[4*DW +: DW] = DW'(-20000);
    cycle(1, 0, 0, '0, b);
    repeat (2) cycle(0, 1, 0, d, '0);
    cycle(0, 0, 1, '0, '0);
    wait_drain();

    // accumulator saturation at both ACC_WIDTH limits
    b = '0;
    b[0*DW +: DW] = 16'h7FFF;
    b[1*DW +: DW] = 16'h8000;
    cycle(1, 0, 0, '0, b);
    for (int i = 0; i < 260; i++) begin
      d = rand_vec(-32768, 32767);
      d[0*DW +: DW] = 16'h7FFF;
      d[1*DW +: DW] = 16'h8000;
      cycle(0, 1, 0, d, '0);
    end
    cycle(0, 0, 1, '0, '0);
    wait_drain();

    // backpressure 1,0,0 pattern
    ready_mode = 1;
    cycle(1, 0, 0, '0, rand_vec(-20000, 20000));
    repeat (5) cycle(0, 1, 0, rand_vec(-3000, 3000), '0);
    cycle(0, 0, 1, '0, '0);
    wait_drain();
    ready_mode = 0;

    // ties keep the lowest index
    b = rand_vec(-1000, 499);
    b[2*DW +: DW] = DW'(500);
    b[7*DW +: DW] = DW'(500);
    cycle(1, 0, 0, '0, b);
    cycle(0, 0, 1, '0, '0);
    wait_drain();

    // bias_sel wins over acc_en
    cycle(1, 0, 0, '0, rand_vec(-500, 500));
    cycle(1, 1, 0, rand_vec(-500, 500), rand_vec(-500, 500));
    cycle(0, 0, 1, '0, '0);
    wait_drain();

    // done with acc_en includes that addition; done with bias_sel stays in ACC
    cycle(1, 0, 0, '0, rand_vec(-500, 500));
    cycle(1, 0, 1, '0, rand_vec(-500, 500));
    check("bias_beats_done_valid", 64'(out_valid), 64'(0));
    check("bias_beats_done_busy", 64'(busy), 64'(1));
    cycle(0, 1, 0, rand_vec(-500, 500), '0);
    cycle(0, 1, 1, rand_vec(-500, 500), '0);
    wait_drain();

    // reset after four handshakes
    cycle(1, 0, 0, '0, rand_vec(-5000, 5000));
    h0 = hs_cnt;
    cycle(0, 0, 1, '0, '0);
    n = 0;
    while (hs_cnt - h0 < 4 && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("reset_wait_hs", 64'(hs_cnt - h0 >= 4), 64'(1));
    @(posedge clk);
    #2;
    reset = 1;
    #1;
    check("mid_reset_valid", 64'(out_valid), 64'(0));
    check("mid_reset_busy", 64'(busy), 64'(0));
    check("mid_reset_class", 64'(class_valid), 64'(0));
    exp_q.delete();
    cls_q.delete();
    m_draining = 0;
    m_active = 0;
    for (int k = 0; k < NC; k++) m_acc[k] = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    cycle(1, 0, 0, '0, rand_vec(-5000, 5000));
    cycle(0, 1, 1, rand_vec(-5000, 5000), '0);
    wait_drain();

    // all negative except channel 5 = -1
    b = rand_vec(-30000, -2);
    b[5*DW +: DW] = DW'(-1);
    cycle(1, 0, 0, '0, b);
    cycle(0, 0, 1, '0, '0);
    wait_drain();

    // random runs with random backpressure
    ready_mode = 2;
    for (int r = 0; r < 6; r++) begin
      cycle(1, 0, 0, '0, rand_vec(-32768, 32767));
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 7) == 0)
          cycle(1, 1, 0, rand_vec(-32768, 32767), rand_vec(-32768, 32767));
        else
          cycle(0, 1, 0, rand_vec(-32768, 32767), '0);
      end
      cycle(0, $urandom_range(0, 1) == 1, 1, rand_vec(-32768, 32767), '0);
      wait_drain();
    end
    ready_mode = 0;

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
